// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, repeated with optional idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int DIV   = 1,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       repeat_cnt,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

`ifdef SEQ_TX_PARITY_EN
  localparam int B = PAT_W + 1;
`else
  localparam int B = PAT_W;
`endif
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(B + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t             state;
  logic [PAT_W-1:0]   pat_q;
  logic [PAT_W-1:0]   shift_reg;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         reps_left;
  logic [3:0]         gap_cnt;

  // shift_reg holds the bits still to be sent; out_bit already carries the current one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pat_q     <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      reps_left <= '0;
      gap_cnt   <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pat_q     <= pattern;
            reps_left <= repeat_cnt;
            shift_reg <= pattern << 1;
            out_bit   <= pattern[PAT_W-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (div_cnt != DIV_W'(DIV - 1)) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (bit_cnt == CNT_W'(B - 1)) begin
              bit_cnt <= '0;
              if (reps_left == 4'd0) begin
                state     <= S_DONE;
                out_bit   <= 1'b0;
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                reps_left <= reps_left - 4'd1;
                if (GAP > 0) begin
                  state     <= S_GAP;
                  gap_cnt   <= '0;
                  out_bit   <= 1'b0;
                  out_valid <= 1'b0;
                end else begin
                  shift_reg <= pat_q << 1;
                  out_bit   <= pat_q[PAT_W-1];
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
`ifdef SEQ_TX_PARITY_EN
              if (bit_cnt == CNT_W'(PAT_W - 1)) begin
                out_bit <= ^pat_q;
              end else begin
                out_bit   <= shift_reg[PAT_W-1];
                shift_reg <= shift_reg << 1;
              end
`else
              out_bit   <= shift_reg[PAT_W-1];
              shift_reg <= shift_reg << 1;
`endif
            end
          end
        end
        S_GAP: begin
          if (div_cnt != DIV_W'(DIV - 1)) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (gap_cnt == 4'(GAP - 1)) begin
              state     <= S_SHIFT;
              shift_reg <= pat_q << 1;
              out_bit   <= pat_q[PAT_W-1];
              out_valid <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
